avr_hvpp_target: RTL and testbench

//  Synthesizable responder model of an ATtiny26-class AVR in high-voltage parallel programming mode:
//  the DUT-side end of the bottomhalf pin interface (XTAL1/XA0/XA1-BS2/PAGEL-BS1/WR/OE/data/RDY).

---
 rtl/avr_hvpp_pkg.sv | 45 ++++
 rtl/avr_hvpp_target_if.sv | 23 ++
 rtl/avr_pin_sync.sv | 35 +++
 rtl/avr_hvpp_target.sv | 210 +++++++++++++++++++++
 tb/tb_avr_hvpp_target.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avr_hvpp_pkg.sv
// Shared constants and types for the AVR high-voltage parallel programming target:
// command codes, XTAL1 load types, FSM states, control-pin bit positions.
package avr_hvpp_pkg;

  localparam logic [7:0] CMD_ERASE    = 8'h80;
  localparam logic [7:0] CMD_WR_FLASH = 8'h10;
  localparam logic [7:0] CMD_WR_FUSE  = 8'h40;
  localparam logic [7:0] CMD_RD_FLASH = 8'h02;
  localparam logic [7:0] CMD_RD_FUSE  = 8'h04;
  localparam logic [7:0] CMD_RD_SIG   = 8'h08;

  typedef enum logic [1:0] {
    LD_ADDR = 2'b00,
    LD_DATA = 2'b01,
    LD_CMD  = 2'b10,
    LD_NONE = 2'b11
  } load_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PROG  = 2'b01,
    ST_ERASE = 2'b10
  } state_e;

  localparam int PIN_XTAL1 = 0;
  localparam int PIN_XA0   = 1;
  localparam int PIN_XA1   = 2;
  localparam int PIN_BS1   = 3;
  localparam int PIN_WR_N  = 4;
  localparam int PIN_OE_N  = 5;

  localparam int CNT_W = 16;

  function automatic logic [7:0] sig_byte(input logic [23:0] sig, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = sig[23:16];
      2'd1:    b = sig[15:8];
      2'd2:    b = sig[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/avr_hvpp_target_if.sv
// Pin bundle between the HVPP programmer (master) and the target model (slave).
interface avr_hvpp_target_if;
  logic       xtal1;
  logic       xa0;
  logic       xa1_bs2;
  logic       pagel_bs1;
  logic       wr_n;
  logic       oe_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       rdy;

  modport master (
    output xtal1, xa0, xa1_bs2, pagel_bs1, wr_n, oe_n, data_in,
    input  data_out, data_oe, rdy
  );

  modport slave (
    input  xtal1, xa0, xa1_bs2, pagel_bs1, wr_n, oe_n, data_in,
    output data_out, data_oe, rdy
  );
endinterface

// File: rtl/avr_pin_sync.sv
// Two-flop synchronizer with a history register; reports level and single-cycle
// rise/fall pulses per bit. RST_VAL is the idle level so reset creates no edges.
module avr_pin_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/avr_hvpp_target.sv
// ATtiny26-class target in high-voltage parallel programming mode: decodes XTAL1
// loads and WR/OE strobes against a small flash array, a fuse byte and the signature.
module avr_hvpp_target
  import avr_hvpp_pkg::*;
#(
  parameter int          FLASH_AW     = 7,
  parameter logic [23:0] SIG          = 24'h1E9109,
  parameter logic [7:0]  FUSE_DEFAULT = 8'hE1,
  parameter int          PROG_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               rst,
  avr_hvpp_target_if.slave   pins
);

  localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'((1 << FLASH_AW) - 1);

  logic [5:0]          w_ctl_async;
  logic [5:0]          w_ctl_lvl;
  logic [5:0]          w_ctl_rise;
  logic [5:0]          w_ctl_fall;
  logic [7:0]          r_din_meta;
  logic [7:0]          r_din_sync;
  logic                w_xtal_rise;
  logic                w_wr_fall;
  logic                w_bs1;
  load_e               w_ld;
  logic [15:0]         r_addr;
  logic [7:0]          r_dlo;
  logic [7:0]          r_dhi;
  logic [7:0]          r_cmd;
  logic [7:0]          r_fuse;
  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rdy;
  logic                w_ram_we;
  logic [FLASH_AW-1:0] w_ram_addr;
  logic [15:0]         w_ram_wdata;
  logic                w_fuse_we;
  logic [7:0]          w_fuse_wdata;
  logic [15:0]         r_ram_rdata;
  logic [15:0]         r_mem [0:(1 << FLASH_AW) - 1];
  logic [7:0]          w_dout_nxt;
  logic [7:0]          r_dout;
  logic                w_unused_bits;

  assign w_ctl_async = {pins.oe_n, pins.wr_n, pins.pagel_bs1,
                        pins.xa1_bs2, pins.xa0, pins.xtal1};

  avr_pin_sync #(
    .WIDTH   (6),
    .RST_VAL (6'b110000)
  ) u_ctl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (w_ctl_async),
    .o_level (w_ctl_lvl),
    .o_rise  (w_ctl_rise),
    .o_fall  (w_ctl_fall)
  );

  // Data bus only needs its level, aligned with the control-pin sync depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din_meta <= 8'h00;
      r_din_sync <= 8'h00;
    end else begin
      r_din_meta <= pins.data_in;
      r_din_sync <= r_din_meta;
    end
  end

  assign w_xtal_rise = w_ctl_rise[PIN_XTAL1];
  assign w_wr_fall   = w_ctl_fall[PIN_WR_N];
  assign w_bs1       = w_ctl_lvl[PIN_BS1];
  assign w_ld        = load_e'({w_ctl_lvl[PIN_XA1], w_ctl_lvl[PIN_XA0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= 16'h0000;
      r_dlo  <= 8'h00;
      r_dhi  <= 8'h00;
      r_cmd  <= 8'h00;
    end else if (w_xtal_rise) begin
      case (w_ld)
        LD_ADDR: begin
          if (w_bs1) r_addr[15:8] <= r_din_sync;
          else       r_addr[7:0]  <= r_din_sync;
        end
        LD_DATA: begin
          if (w_bs1) r_dhi <= r_din_sync;
          else       r_dlo <= r_din_sync;
        end
        LD_CMD:  r_cmd <= r_din_sync;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // wr_n strobes are only decoded in IDLE, which makes a strobe during busy a no-op.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_fall && (r_cmd == CMD_ERASE))         w_state_nxt = ST_ERASE;
        else if (w_wr_fall && ((r_cmd == CMD_WR_FLASH) ||
                               (r_cmd == CMD_WR_FUSE))) w_state_nxt = ST_PROG;
        else                                            w_state_nxt = ST_IDLE;
      end
      ST_PROG: begin
        if (r_cnt == PROG_LAST) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_PROG;
      end
      ST_ERASE: begin
        if (r_cnt == ERASE_LAST) w_state_nxt = ST_IDLE;
        else                     w_state_nxt = ST_ERASE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ram_we     = 1'b0;
    w_ram_addr   = r_addr[FLASH_AW-1:0];
    w_ram_wdata  = {r_dhi, r_dlo};
    w_fuse_we    = 1'b0;
    w_fuse_wdata = r_dlo;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_fall && (r_cmd == CMD_WR_FLASH)) begin
          w_ram_we  = 1'b1;
          w_fuse_we = 1'b0;
        end else if (w_wr_fall && (r_cmd == CMD_WR_FUSE)) begin
          w_ram_we  = 1'b0;
          w_fuse_we = 1'b1;
        end else begin
          w_ram_we  = 1'b0;
          w_fuse_we = 1'b0;
        end
      end
      ST_ERASE: begin
        w_ram_we     = 1'b1;
        w_ram_addr   = r_cnt[FLASH_AW-1:0];
        w_ram_wdata  = 16'hFFFF;
        w_fuse_we    = 1'b1;
        w_fuse_wdata = FUSE_DEFAULT;
      end
      default: begin
        w_ram_we  = 1'b0;
        w_fuse_we = 1'b0;
      end
    endcase
  end

  // Counter restarts at zero on every entry to a busy state.
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE) || (w_state_nxt == ST_IDLE)) r_cnt <= {CNT_W{1'b0}};
    else                                                          r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_rdy <= 1'b1;
    else     r_rdy <= (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)            r_fuse <= FUSE_DEFAULT;
    else if (w_fuse_we) r_fuse <= w_fuse_wdata;
  end

  // Single-port RAM without reset: write wins, read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (w_ram_we && !rst) r_mem[w_ram_addr] <= w_ram_wdata;
    r_ram_rdata <= r_mem[w_ram_addr];
  end

  always_comb begin
    w_dout_nxt = 8'hFF;
    if (r_state != ST_IDLE) begin
      w_dout_nxt = 8'hFF;
    end else begin
      case (r_cmd)
        CMD_RD_FLASH: w_dout_nxt = w_bs1 ? r_ram_rdata[15:8] : r_ram_rdata[7:0];
        CMD_RD_SIG:   w_dout_nxt = sig_byte(SIG, r_addr[1:0]);
        CMD_RD_FUSE:  w_dout_nxt = r_fuse;
        default:      w_dout_nxt = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_dout <= 8'h00;
    else     r_dout <= w_dout_nxt;
  end

  assign pins.data_out = r_dout;
  assign pins.data_oe  = ~w_ctl_lvl[PIN_OE_N];
  assign pins.rdy      = r_rdy;

  assign w_unused_bits = ^{w_ctl_rise[5:1], w_ctl_fall[5], w_ctl_fall[3:0],
                           r_addr[15:FLASH_AW]};

endmodule

// File: tb/tb_avr_hvpp_target.sv
// Directed bench for avr_hvpp_target with a transaction-level model of the target state
// and a per-cycle compare process active whenever the pins have been quiet long enough.
module tb_avr_hvpp_target;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avr_hvpp_target_if bus();

  avr_hvpp_target #(
    .FLASH_AW     (7),
    .SIG          (24'h1E9109),
    .FUSE_DEFAULT (8'hE1),
    .PROG_CYCLES  (64)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (bus.slave)
  );

  int n_cmp    = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_chg = 0;
  bit m_busy   = 1'b1;
  bit chk_on   = 1'b0;

  logic [7:0]  m_cmd, m_dlo, m_dhi, m_fuse;
  logic [15:0] m_addr;
  logic [15:0] m_flash [128];
  bit          m_known [128];
  logic [7:0]  m_sig   [4] = '{8'h1E, 8'h91, 8'h09, 8'hFF};

  function automatic void m_reset();
    m_cmd  = 8'h00;
    m_addr = 16'h0000;
    m_dlo  = 8'h00;
    m_dhi  = 8'h00;
    m_fuse = 8'hE1;
  endfunction

  function automatic void m_load(input logic [1:0] ld, input logic bs1, input logic [7:0] d);
    if (ld == 2'b00) begin
      if (bs1) m_addr[15:8] = d; else m_addr[7:0] = d;
    end else if (ld == 2'b01) begin
      if (bs1) m_dhi = d; else m_dlo = d;
    end else if (ld == 2'b10) begin
      m_cmd = d;
    end
  endfunction

  function automatic void m_wr(input bit aborted);
    if (m_cmd == 8'h10) begin
      m_flash[m_addr[6:0]] = {m_dhi, m_dlo};
      m_known[m_addr[6:0]] = 1'b1;
    end else if (m_cmd == 8'h40) begin
      m_fuse = m_dlo;
    end else if (m_cmd == 8'h80) begin
      m_fuse = 8'hE1;
      for (int k = 0; k < 128; k++) begin
        if (!aborted) begin
          m_flash[k] = 16'hFFFF;
          m_known[k] = 1'b1;
        end else if (k < 64) begin
          m_known[k] = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] exp_dout(output bit valid);
    logic [15:0] w;
    valid = 1'b1;
    if (m_cmd == 8'h02) begin
      w     = m_flash[m_addr[6:0]];
      valid = m_known[m_addr[6:0]];
      return bus.pagel_bs1 ? w[15:8] : w[7:0];
    end else if (m_cmd == 8'h08) begin
      return m_sig[m_addr[1:0]];
    end else if (m_cmd == 8'h04) begin
      return m_fuse;
    end
    return 8'hFF;
  endfunction

  always @(negedge clk) begin
    logic [7:0] e;
    bit         v;
    cyc++;
    if (chk_on && !rst && !m_busy && ((cyc - last_chg) > 8)) begin
      n_cmp++;
      if (bus.rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_rdy cyc=%0d: got %b want 1", cyc, bus.rdy);
      end
      n_cmp++;
      if (bus.data_oe !== ~bus.oe_n) begin
        n_fail++;
        $display("FAIL data_oe cyc=%0d: got %b want %b", cyc, bus.data_oe, ~bus.oe_n);
      end
      e = exp_dout(v);
      if (v) begin
        n_cmp++;
        if (bus.data_out !== e) begin
          n_fail++;
          $display("FAIL data_out cyc=%0d cmd=%h: got %h want %h", cyc, m_cmd, bus.data_out, e);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chg();
    last_chg = cyc;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic xload(input logic [1:0] ld, input logic bs1, input logic [7:0] d);
    bus.xa1_bs2   = ld[1];
    bus.xa0       = ld[0];
    bus.pagel_bs1 = bs1;
    bus.data_in   = d;
    chg();
    hold(3);
    bus.xtal1 = 1'b1;
    m_load(ld, bs1, d);
    chg();
    hold(3);
    bus.xtal1 = 1'b0;
    chg();
    hold(2);
  endtask

  task automatic rd(input logic bs1, input logic [7:0] exp, input string nm);
    bus.pagel_bs1 = bs1;
    chg();
    hold(8);
    check(nm, {8'h00, bus.data_out}, {8'h00, exp});
  endtask

  // wr_n strobe; counts rdy-low cycles. extra_at injects a second strobe while busy,
  // abort_at pulses rst once that many busy cycles were seen, collide adds an xtal1 cmd load.
  task automatic wr_op(input int exp_len, input int extra_at, input int abort_at,
                       input bit collide, input string nm);
    int low;
    bit done;
    low    = 0;
    done   = 1'b0;
    m_busy = 1'b1;
    m_wr(abort_at > 0);
    bus.wr_n = 1'b0;
    if (collide) begin
      bus.xtal1 = 1'b1;
      m_load(2'b10, bus.pagel_bs1, bus.data_in);
    end
    chg();
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.wr_n  = 1'b1;
        bus.xtal1 = 1'b0;
      end
      if (extra_at > 0 && i == extra_at)     bus.wr_n = 1'b0;
      if (extra_at > 0 && i == extra_at + 3) bus.wr_n = 1'b1;
      if (bus.rdy === 1'b0) low++;
      else if (low > 0)     done = 1'b1;
      if (abort_at > 0 && low == abort_at && !done) begin
        rst = 1'b1;
        @(negedge clk);
        check({nm, "_rdy_after_rst"}, {15'h0000, bus.rdy}, 16'h0001);
        rst = 1'b0;
        m_reset();
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout, rdy low %0d cycles, want %0d", nm, low, exp_len);
    end else if (abort_at == 0) begin
      check(nm, 16'(low), 16'(exp_len));
    end
    chg();
    m_busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sig_exp [4];
    sig_exp = '{8'h1E, 8'h91, 8'h09, 8'hFF};
    for (int k = 0; k < 128; k++) begin
      m_flash[k] = 16'h0000;
      m_known[k] = 1'b0;
    end
    bus.xtal1 = 1'b0; bus.xa0 = 1'b0; bus.xa1_bs2 = 1'b0; bus.pagel_bs1 = 1'b0;
    bus.wr_n = 1'b1; bus.oe_n = 1'b1; bus.data_in = 8'h00;
    hold(2);
    rst = 1'b1;
    hold(1);
    check("rst_rdy",      {15'h0000, bus.rdy},     16'h0001);
    check("rst_data_oe",  {15'h0000, bus.data_oe}, 16'h0000);
    check("rst_data_out", {8'h00, bus.data_out},   16'h0000);
    rst = 1'b0;
    m_reset();
    m_busy = 1'b0;
    chk_on = 1'b1;
    chg();

    xload(2'b10, 1'b0, 8'h04);
    bus.oe_n = 1'b0;
    chg();
    hold(8);
    check("oe_on", {15'h0000, bus.data_oe}, 16'h0001);
    rd(1'b0, 8'hE1, "fuse_reset");

    xload(2'b00, 1'b0, 8'h05); xload(2'b00, 1'b1, 8'h00);
    xload(2'b01, 1'b0, 8'h34); xload(2'b01, 1'b1, 8'h12);
    xload(2'b10, 1'b0, 8'h10);
    wr_op(64, 0, 0, 1'b0, "prog_len");
    xload(2'b10, 1'b0, 8'h02);
    rd(1'b0, 8'h34, "flash5_lo");
    rd(1'b1, 8'h12, "flash5_hi");

    xload(2'b10, 1'b0, 8'h08);
    for (int a = 0; a < 4; a++) begin
      xload(2'b00, 1'b0, 8'(a));
      rd(1'b0, sig_exp[a], "sig_byte");
    end

    xload(2'b01, 1'b0, 8'h5A);
    xload(2'b10, 1'b0, 8'h40);
    wr_op(64, 0, 0, 1'b0, "fuse_prog_len");
    xload(2'b10, 1'b0, 8'h04);
    rd(1'b0, 8'h5A, "fuse_prog");

    xload(2'b00, 1'b0, 8'h7F);
    xload(2'b01, 1'b0, 8'h5A); xload(2'b01, 1'b1, 8'hA5);
    xload(2'b10, 1'b0, 8'h10);
    wr_op(64, 0, 0, 1'b0, "prog127_len");
    xload(2'b10, 1'b0, 8'h80);
    wr_op(128, 0, 0, 1'b0, "erase_len");
    xload(2'b10, 1'b0, 8'h02);
    rd(1'b0, 8'hFF, "erase127_lo");
    rd(1'b1, 8'hFF, "erase127_hi");
    xload(2'b00, 1'b0, 8'h05);
    rd(1'b0, 8'hFF, "erase5_lo");
    rd(1'b1, 8'hFF, "erase5_hi");
    xload(2'b10, 1'b0, 8'h04);
    rd(1'b0, 8'hE1, "fuse_erased");

    xload(2'b01, 1'b0, 8'hCD); xload(2'b01, 1'b1, 8'hAB);
    xload(2'b10, 1'b0, 8'h10);
    wr_op(64, 20, 0, 1'b0, "busy_len");
    xload(2'b10, 1'b0, 8'h02);
    rd(1'b0, 8'hCD, "busy5_lo");
    rd(1'b1, 8'hAB, "busy5_hi");

    xload(2'b00, 1'b0, 8'h7F);
    xload(2'b01, 1'b0, 8'hEF); xload(2'b01, 1'b1, 8'hBE);
    xload(2'b10, 1'b0, 8'h10);
    wr_op(64, 0, 0, 1'b0, "prog127b_len");
    xload(2'b10, 1'b0, 8'h80);
    wr_op(128, 0, 40, 1'b0, "abort");
    xload(2'b00, 1'b0, 8'h7F);
    xload(2'b10, 1'b0, 8'h02);
    rd(1'b0, 8'hEF, "abort127_lo");
    rd(1'b1, 8'hBE, "abort127_hi");

    xload(2'b00, 1'b0, 8'h10);
    xload(2'b01, 1'b0, 8'h77); xload(2'b01, 1'b1, 8'h66);
    xload(2'b10, 1'b0, 8'h10);
    bus.xa1_bs2 = 1'b1; bus.xa0 = 1'b0; bus.pagel_bs1 = 1'b0; bus.data_in = 8'h40;
    chg();
    hold(3);
    wr_op(64, 0, 0, 1'b1, "collide_len");
    rd(1'b0, 8'hFF, "cmd40_dout");
    wr_op(64, 0, 0, 1'b0, "cmd40_prog_len");
    xload(2'b10, 1'b0, 8'h04);
    rd(1'b0, 8'h77, "fuse_after_collide");
    xload(2'b10, 1'b0, 8'h02);
    rd(1'b0, 8'h77, "collide_lo");
    rd(1'b1, 8'h66, "collide_hi");

    bus.oe_n = 1'b1;
    chg();
    hold(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
